// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial unsigned subtractor. A single full-subtractor cell with a
// registered borrow is iterated LSB-first over WIDTH clock cycles to compute
// diff = a - b (mod 2^WIDTH), the final borrow (a < b) and a zero flag.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset (priority over everything)
//   start  - operation request, sampled only while busy=0 (IDLE or DONE)
//   a, b   - minuend / subtrahend, captured on an accepted start
//   busy   - high while the RUN state is active
//   done   - one-cycle pulse; diff/borrow/zero are valid from this cycle on
//   diff   - a - b modulo 2^WIDTH
//   borrow - 1 iff a < b (unsigned)
//   zero   - 1 iff diff == 0
//
// Timing: start sampled at edge k -> busy high after edges k..k+WIDTH-1,
// done high for the cycle after edge k+WIDTH. One result per WIDTH+1 cycles,
// and a start during the done cycle is accepted for back-to-back use.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] res_reg;
    logic             br_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;

    // Full-subtractor cell operating on the current LSBs.
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    always_comb begin
        d_bit    = sa_reg[0] ^ sb_reg[0] ^ br_reg;
        br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
        // Result fills from the MSB end so that after WIDTH shifts the
        // first (LSB) difference bit has arrived at bit 0.
        res_next = {d_bit, res_reg[WIDTH-1:1]};
        last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            sa_reg     <= '0;
            sb_reg     <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            zero_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                // DONE behaves like IDLE for start acceptance; it only
                // differs in that done is high during it.
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        sa_reg    <= a;
                        sb_reg    <= b;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // start is deliberately not looked at here.
                    sa_reg  <= {1'b0, sa_reg[WIDTH-1:1]};
                    sb_reg  <= {1'b0, sb_reg[WIDTH-1:1]};
                    res_reg <= res_next;
                    br_reg  <= br_next;
                    if (last_bit) begin
                        diff_reg   <= res_next;
                        borrow_reg <= br_next;
                        zero_reg   <= (res_next == '0);
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor: an 8-bit instance for the
// handshake/arithmetic scenarios and a 4-bit instance for an exhaustive sweep.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow, zero;
    logic [7:0] diff;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, borrow4, zero4;
    logic [3:0] diff4;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(8), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .zero(zero)
    );

    serial_subtractor #(.WIDTH(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .zero(zero4)
    );

    // Stimulus helper: one-cycle start pulse on the 8-bit instance.
    // Returns at the falling edge right after the sampling edge.
    task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stimulus helper: counts busy cycles until done is seen or a bound runs out.
    task automatic wait_done(output int busy_cnt, output bit timed_out);
        busy_cnt  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_done: got %b required 00", {busy, done});
        end
        checks++;
        if ({diff, borrow, zero} !== 10'h000) begin
            errors++;
            $display("FAIL reset_results: got diff=%h borrow=%b zero=%b required 00 0 0", diff, borrow, zero);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: busy=%b done=%b diff=%h borrow=%b zero=%b", busy, done, diff, borrow, zero);
    endtask

    task automatic test_basic;
        int  bc;
        bit  to;
        pulse_start(8'h05, 8'h03);
        wait_done(bc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL basic_timeout: got no done required done");
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d required 8", bc);
        end
        checks++;
        if ({diff, borrow, zero} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got diff=%h borrow=%b zero=%b required 02 0 0", diff, borrow, zero);
        end
        $display("basic: 05-03 -> diff=%h borrow=%b zero=%b busy_cycles=%0d", diff, borrow, zero, bc);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b required 0", done);
        end
        checks++;
        if (diff !== 8'h02) begin
            errors++;
            $display("FAIL basic_hold: got diff=%h required 02", diff);
        end
    endtask

    // Directed vectors with hand-computed results: {a, b, diff, borrow, zero}.
    task automatic test_arith;
        logic [7:0] va [6] = '{8'h03, 8'h00, 8'hA5, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] vb [6] = '{8'h05, 8'hFF, 8'hA5, 8'h01, 8'h80, 8'h80};
        logic [7:0] vd [6] = '{8'hFE, 8'h01, 8'h00, 8'hFE, 8'h00, 8'hFF};
        logic       vbr[6] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        logic       vz [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        int  bc;
        bit  to;
        for (int i = 0; i < 6; i++) begin
            pulse_start(va[i], vb[i]);
            wait_done(bc, to);
            checks++;
            if (to || {diff, borrow, zero} !== {vd[i], vbr[i], vz[i]}) begin
                errors++;
                $display("FAIL arith_%0d: %h-%h got diff=%h borrow=%b zero=%b timeout=%b required %h %b %b",
                         i, va[i], vb[i], diff, borrow, zero, to, vd[i], vbr[i], vz[i]);
            end
            $display("arith: %h-%h -> diff=%h borrow=%b zero=%b", va[i], vb[i], diff, borrow, zero);
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int bc;
        bit to;
        pulse_start(8'h40, 8'h13);   // busy cycle 1 at this point
        @(negedge clk);              // busy cycle 2
        // Busy cycle 3: a stray start with new operands, which also stay changed.
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, to);
        checks++;
        if (to || bc !== 6) begin
            errors++;
            $display("FAIL ignore_busy_len: got %0d remaining busy cycles timeout=%b required 6", bc, to);
        end
        checks++;
        if ({diff, borrow, zero} !== {8'h2D, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result: got diff=%h borrow=%b zero=%b required 2d 0 0", diff, borrow, zero);
        end
        $display("ignore_start: 40-13 with stray 11-22 -> diff=%h borrow=%b", diff, borrow);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_no_requeue: got busy,done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_back_to_back;
        int bc;
        bit to;
        pulse_start(8'h20, 8'h01);
        wait_done(bc, to);
        checks++;
        if (to || diff !== 8'h1F) begin
            errors++;
            $display("FAIL b2b_first: got diff=%h timeout=%b required 1f", diff, to);
        end
        // Now in the done cycle: start again.
        pulse_start(8'h10, 8'h01);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept: got busy,done=%b required 10", {busy, done});
        end
        checks++;
        if (diff !== 8'h1F) begin
            errors++;
            $display("FAIL b2b_hold: got diff=%h required 1f", diff);
        end
        wait_done(bc, to);
        checks++;
        if (to || bc !== 8 || {diff, borrow, zero} !== {8'h0F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got diff=%h borrow=%b zero=%b busy=%0d timeout=%b required 0f 0 0 8",
                     diff, borrow, zero, bc, to);
        end
        $display("back_to_back: 20-01 then 10-01 -> diff=%h busy_cycles=%0d", diff, bc);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bc;
        bit to;
        bit seen_done;
        pulse_start(8'h33, 8'h11);   // busy cycle 1
        repeat (3) @(negedge clk);   // busy cycle 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, diff, borrow, zero} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_clear: got busy=%b done=%b diff=%h borrow=%b zero=%b required all 0",
                     busy, done, diff, borrow, zero);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: got activity after abort required none");
        end
        pulse_start(8'h09, 8'h04);
        wait_done(bc, to);
        checks++;
        if (to || {diff, borrow, zero} !== {8'h05, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_after: got diff=%h borrow=%b zero=%b timeout=%b required 05 0 0",
                     diff, borrow, zero, to);
        end
        $display("reset_mid: aborted 33-11, then 09-04 -> diff=%h", diff);
        @(negedge clk);
    endtask

    task automatic test_exhaustive4;
        int spacing [2] = '{0, 3};
        logic [4:0] expv;
        int  bc;
        bit  to;
        int  errs_before;
        for (int s = 0; s < 2; s++) begin
            errs_before = errors;
            for (int i = 0; i < 256; i++) begin
                a4 = 4'(i >> 4);
                b4 = 4'(i);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                bc = 0;
                to = 1'b1;
                for (int k = 0; k < 50; k++) begin
                    if (done4) begin
                        to = 1'b0;
                        break;
                    end
                    if (busy4) bc++;
                    @(negedge clk);
                end
                expv = {1'b0, a4} - {1'b0, b4};
                checks++;
                if (to || bc !== 4 || {borrow4, diff4} !== expv || zero4 !== (expv[3:0] == 4'h0)) begin
                    errors++;
                    $display("FAIL exh4: %h-%h got borrow=%b diff=%h zero=%b busy=%0d timeout=%b required %b %h %b 4",
                             a4, b4, borrow4, diff4, zero4, bc, to, expv[4], expv[3:0], expv[3:0] == 4'h0);
                end
                repeat (spacing[s]) @(negedge clk);
            end
            $display("exhaustive4: spacing=%0d 256 pairs, new errors=%0d", spacing[s], errors - errs_before);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_arith;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_exhaustive4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
